// File: rtl/memory_subsystem.sv
// memory_subsystem: word-addressed synchronous memory answering MAR/MDR read
// and write requests with a single-cycle Done pulse after WAIT_STATES busy
// cycles. Compile-time option MEM_WAIT_STATES_EN: when defined, the BUSY state
// and wait counter are built in and WAIT_STATES is honoured; when undefined,
// every access completes the cycle after acceptance.
module memory_subsystem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] BusData,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // The wait counter is 4 bits wide, so larger settings cannot be honoured.
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_range
        $error("memory_subsystem: WAIT_STATES must be in 0..15");
    end

    state_t              state;
    logic [ADDR_W-1:0]   addr_lat;
    logic [DATA_W-1:0]   data_lat;
    logic                op_read_lat;
    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

`ifdef MEM_WAIT_STATES_EN
    localparam logic [3:0] WAIT_INIT = WAIT_STATES[3:0];
    logic [3:0]          wait_cnt;
`endif

    logic                req;
    logic                acc_now;
    logic                acc_read;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic                wr_en;

    assign req = Read | Write;

    // Decide whether the array is accessed on this edge and with which operands:
    // live inputs when going straight from IDLE to DONE, latched values otherwise.
    always_comb begin
        acc_now  = 1'b0;
        acc_read = op_read_lat;
        acc_addr = addr_lat;
        acc_data = data_lat;
        case (state)
            IDLE: begin
`ifdef MEM_WAIT_STATES_EN
                if (req && (WAIT_STATES == 0)) begin
`else
                if (req) begin
`endif
                    acc_now  = 1'b1;
                    acc_read = Read;
                    acc_addr = Address;
                    acc_data = BusData;
                end
            end
`ifdef MEM_WAIT_STATES_EN
            BUSY: begin
                if (wait_cnt == 4'd1) begin
                    acc_now = 1'b1;
                end
            end
`endif
            default: begin
                acc_now = 1'b0;
            end
        endcase
    end

    // A write never lands while Clear is asserted, so an aborted access leaves memory untouched.
    assign wr_en = acc_now & ~acc_read & Clear;

    // Storage array: no reset, contents undefined at power-up.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[acc_addr] <= acc_data;
        end
    end

    // Access sequencer: latches the request in IDLE, counts wait states, pulses Done.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state       <= IDLE;
            addr_lat    <= '0;
            data_lat    <= '0;
            op_read_lat <= 1'b0;
            Mdatain     <= '0;
            Done        <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
            wait_cnt    <= 4'd0;
`endif
        end else begin
            Done <= 1'b0;
            if (acc_now && acc_read) begin
                Mdatain <= mem[acc_addr];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_lat    <= Address;
                        data_lat    <= BusData;
                        op_read_lat <= Read;
`ifdef MEM_WAIT_STATES_EN
                        if (WAIT_STATES == 0) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            state    <= BUSY;
                            wait_cnt <= WAIT_INIT;
                        end
`else
                        state <= DONE;
                        Done  <= 1'b1;
`endif
                    end
                end
`ifdef MEM_WAIT_STATES_EN
                BUSY: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_subsystem.sv
// Scoreboard bench for memory_subsystem: stimulus pushes expected Done timing
// and read data into a queue; a negedge monitor pops and compares on each Done.
module tb_memory_subsystem;

`ifdef MEM_WAIT_STATES_EN
    localparam int WS  = 2;
    localparam int LAT = WS;
`else
    localparam int WS  = 5;
    localparam int LAT = 0;
`endif

    logic        Clock;
    logic        Clear;
    logic        Read;
    logic        Write;
    logic [8:0]  Address;
    logic [31:0] BusData;
    logic [31:0] Mdatain;
    logic        Done;

    memory_subsystem #(
        .DATA_W     (32),
        .ADDR_W     (9),
        .WAIT_STATES(WS)
    ) dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Read   (Read),
        .Write  (Write),
        .Address(Address),
        .BusData(BusData),
        .Mdatain(Mdatain),
        .Done   (Done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        bit          rd;
        bit          known;
        logic [31:0] data;
        int          done_edge;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model[int];
    int          edge_no = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        prev_done = 1'b0;

    always @(posedge Clock) edge_no <= edge_no + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, req, edge_no);
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            chk("done_single", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                chk("done_expected", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_edge", edge_no, e.done_edge);
                if (e.rd && e.known) chk("rdata", Mdatain, e.data);
            end
        end
        prev_done = Done;
    end

    task automatic issue(input bit rd, input bit wr, input logic [8:0] a,
                         input logic [31:0] d, input bit track, output int k);
        exp_t e;
        Read = rd; Write = wr; Address = a; BusData = d;
        @(posedge Clock);
        #1;
        k = edge_no;
        if (track) begin
            e.rd        = rd;
            e.known     = rd && model.exists(int'(a));
            e.data      = e.known ? model[int'(a)] : 32'd0;
            e.done_edge = k + LAT;
            q.push_back(e);
            if (!rd && wr) model[int'(a)] = d;
        end
    endtask

    task automatic wait_done(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(negedge Clock);
            cyc++;
            if (Done === 1'b1) seen++;
        end
        Read = 1'b0; Write = 1'b0;
        chk("done_count", seen, n);
        @(negedge Clock);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d);
        int k;
        issue(rd, wr, a, d, 1'b1, k);
        Read = 1'b0; Write = 1'b0;
        wait_done(1);
    endtask

    task automatic hold_read(input logic [8:0] a, input int n);
        int k;
        exp_t e;
        issue(1'b1, 1'b0, a, 32'd0, 1'b1, k);
        for (int i = 1; i < n; i++) begin
            e.rd        = 1'b1;
            e.known     = model.exists(int'(a));
            e.data      = e.known ? model[int'(a)] : 32'd0;
            e.done_edge = k + LAT + i * (LAT + 2);
            q.push_back(e);
        end
        wait_done(n);
    endtask

    initial begin
        int k;
        Clear = 1'b0; Read = 1'b0; Write = 1'b0; Address = '0; BusData = '0;
        #1;
        chk("reset_mdatain", Mdatain, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        @(negedge Clock); @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);

        // Write then read, plus a read of a never-written word.
        access(1'b0, 1'b1, 9'h012, 32'h80000012);
        access(1'b1, 1'b0, 9'h012, 32'd0);
        access(1'b1, 1'b0, 9'h013, 32'd0);

        // Simultaneous Read+Write: read wins, write dropped.
        access(1'b0, 1'b1, 9'h004, 32'h00000004);
        access(1'b1, 1'b1, 9'h004, 32'h00000018);
        access(1'b1, 1'b0, 9'h004, 32'd0);

        // Changes during BUSY are ignored.
        access(1'b0, 1'b1, 9'h018, 32'h00000018);
        issue(1'b1, 1'b0, 9'h004, 32'd0, 1'b1, k);
        Read = 1'b0; Address = 9'h018; Write = 1'b1; BusData = 32'hDEADBEEF;
        #3;
        Write = 1'b0;
        wait_done(1);
        access(1'b1, 1'b0, 9'h018, 32'd0);

        // Reset mid-write: async clear wipes outputs at once; write is aborted.
        access(1'b0, 1'b1, 9'h020, 32'h11112222);
        access(1'b1, 1'b0, 9'h020, 32'd0);
        issue(1'b0, 1'b1, 9'h020, 32'h14860000, 1'b0, k);
        Read = 1'b0; Write = 1'b0;
        #1;
        Clear = 1'b0;
        #1;
        chk("clear_mdatain", Mdatain, 32'd0);
        chk("clear_done", {31'd0, Done}, 32'd0);
        // With no wait states the write already committed on its acceptance edge.
        if (LAT == 0) model[32'h020] = 32'h14860000;
        @(negedge Clock); @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        access(1'b1, 1'b0, 9'h020, 32'd0);

        // Held strobe: one access every LAT+2 cycles.
        hold_read(9'h012, 3);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 40; i++) begin
            int op;
            logic [8:0] a;
            op = $urandom_range(0, 3);
            a  = 9'h040 + 9'($urandom_range(0, 7));
            case (op)
                0: access(1'b1, 1'b0, a, 32'd0);
                1: access(1'b0, 1'b1, a, $urandom);
                2: access(1'b1, 1'b1, a, $urandom);
                default: hold_read(a, $urandom_range(1, 3));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge Clock);
        end

        repeat (6) @(negedge Clock);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
